// File: rtl/fixed_decoder.sv
// FLAC fixed-predictor decoder: rebuilds 16-bit PCM samples from fixed-prediction
// residuals (orders 0-4) through a two-stage pipeline with one word per enabled cycle.
module fixed_decoder #(
  parameter int RES_W = 24
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iEnable,
  input  logic             iValid,
  input  logic             iStart,
  input  logic [2:0]       iOrder,
  input  logic [RES_W-1:0] iResidual,
  output logic             oValid,
  output logic [15:0]      oSample,
  output logic             oWarmup,
  output logic             oOrderErr
);

  localparam int PW = RES_W + 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_DECODE = 2'd2
  } state_t;

  logic             vld1_q;
  logic             start1_q;
  logic [2:0]       order1_q;
  logic [RES_W-1:0] res1_q;

  state_t      state_q, state_d;
  logic [2:0]  order_q, order_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [15:0] s1_q, s2_q, s3_q, s4_q;
  logic [15:0] s1_d, s2_d, s3_d, s4_d;
  logic        valid_q, valid_d;
  logic [15:0] sample_q, sample_d;
  logic        warm_q, warm_d;
  logic        err_q, err_d;

  state_t      cur_state_s;
  logic [2:0]  cur_order_s;
  logic [2:0]  cur_cnt_s;
  logic [15:0] h1_s, h2_s, h3_s, h4_s;
  logic        accept_s;
  logic signed [PW-1:0] p1_s, p2_s, p3_s, p4_s;
  logic signed [PW-1:0] pred_s, res_ext_s, sum_s;
  logic [15:0] new_sample_s;

  // Stage 2: resolve subframe context, predict, add and derive next state
  always_comb begin
    state_d  = state_q;
    order_d  = order_q;
    wcnt_d   = wcnt_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    s3_d     = s3_q;
    s4_d     = s4_q;
    valid_d  = 1'b0;
    sample_d = sample_q;
    warm_d   = warm_q;
    err_d    = err_q;

    // A start word sees a cleared history and its own (clipped) order
    if (start1_q) begin
      cur_order_s = (order1_q > 3'd4) ? 3'd0 : order1_q;
      cur_state_s = (cur_order_s == 3'd0) ? ST_DECODE : ST_WARMUP;
      cur_cnt_s   = 3'd0;
      h1_s        = 16'd0;
      h2_s        = 16'd0;
      h3_s        = 16'd0;
      h4_s        = 16'd0;
    end else begin
      cur_order_s = order_q;
      cur_state_s = state_q;
      cur_cnt_s   = wcnt_q;
      h1_s        = s1_q;
      h2_s        = s2_q;
      h3_s        = s3_q;
      h4_s        = s4_q;
    end

    accept_s  = vld1_q & (start1_q | (state_q != ST_IDLE));

    p1_s      = {{(PW-16){h1_s[15]}}, h1_s};
    p2_s      = {{(PW-16){h2_s[15]}}, h2_s};
    p3_s      = {{(PW-16){h3_s[15]}}, h3_s};
    p4_s      = {{(PW-16){h4_s[15]}}, h4_s};
    res_ext_s = {{4{res1_q[RES_W-1]}}, res1_q};

    case (cur_order_s)
      3'd1:    pred_s = p1_s;
      3'd2:    pred_s = (p1_s <<< 1) - p2_s;
      3'd3:    pred_s = (p1_s <<< 1) + p1_s - (p2_s <<< 1) - p2_s + p3_s;
      3'd4:    pred_s = (p1_s <<< 2) - (p2_s <<< 2) - (p2_s <<< 1) + (p3_s <<< 2) - p4_s;
      default: pred_s = {PW{1'b0}};
    endcase

    sum_s = res_ext_s + pred_s;

    if (cur_state_s == ST_WARMUP) begin
      new_sample_s = res1_q[15:0];
    end else begin
      new_sample_s = sum_s[15:0];
    end

    if (accept_s) begin
      valid_d  = 1'b1;
      order_d  = cur_order_s;
      sample_d = new_sample_s;
      s1_d     = new_sample_s;
      s2_d     = h1_s;
      s3_d     = h2_s;
      s4_d     = h3_s;
      if (start1_q) begin
        err_d = (order1_q > 3'd4);
      end else begin
        err_d = err_q;
      end
      case (cur_state_s)
        ST_WARMUP: begin
          warm_d  = 1'b1;
          wcnt_d  = cur_cnt_s + 3'd1;
          state_d = ((cur_cnt_s + 3'd1) == cur_order_s) ? ST_DECODE : ST_WARMUP;
        end
        ST_DECODE: begin
          warm_d  = 1'b0;
          wcnt_d  = cur_cnt_s;
          state_d = ST_DECODE;
        end
        default: begin
          warm_d  = 1'b0;
          wcnt_d  = 3'd0;
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      valid_d = 1'b0;
    end
  end

  // Pipeline, FSM, history and output registers; iEnable low freezes everything
  always_ff @(posedge iClock) begin
    if (iReset) begin
      vld1_q   <= 1'b0;
      start1_q <= 1'b0;
      order1_q <= 3'd0;
      res1_q   <= {RES_W{1'b0}};
      state_q  <= ST_IDLE;
      order_q  <= 3'd0;
      wcnt_q   <= 3'd0;
      s1_q     <= 16'd0;
      s2_q     <= 16'd0;
      s3_q     <= 16'd0;
      s4_q     <= 16'd0;
      valid_q  <= 1'b0;
      sample_q <= 16'd0;
      warm_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (iEnable) begin
      vld1_q   <= iValid;
      start1_q <= iValid & iStart;
      order1_q <= iOrder;
      res1_q   <= iResidual;
      state_q  <= state_d;
      order_q  <= order_d;
      wcnt_q   <= wcnt_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      s4_q     <= s4_d;
      valid_q  <= valid_d;
      sample_q <= sample_d;
      warm_q   <= warm_d;
      err_q    <= err_d;
    end
  end

  assign oValid    = valid_q;
  assign oSample   = sample_q;
  assign oWarmup   = warm_q;
  assign oOrderErr = err_q;

endmodule

// File: doc/fixed_decoder.md
Name: fixed_decoder

Overview:
- FLAC fixed-predictor decoder: rebuilds 16-bit PCM samples from a stream of fixed-prediction residuals. Supports prediction orders 0-4.
- Mirror of the fixed encoder path. Sits after the residual (Rice) decoder in the hardware decoder chain and feeds the output sample stream.
- Each subframe starts with a start-flagged word. The first `order` words of the subframe are verbatim warm-up samples; every later word is a residual added to the fixed prediction.

Parameters:
- RES_W, 24, residual input width (signed, two's complement); minimum 17.

Ports:
- iClock  in  1  clock; all logic on the rising edge.
- iReset  in  1  synchronous, active-high reset.
- iEnable  in  1  global advance; when low, all state, including the pipeline, holds.
- iValid  in  1  iResidual/iStart/iOrder carry a word this cycle.
- iStart  in  1  first word of a subframe; qualified by iValid.
- iOrder  in  3  prediction order; sampled only on iValid&iStart.
- iResidual  in  RES_W  signed residual, or warm-up sample in its low 16 bits.
- oValid  out  1  oSample holds a new decoded sample.
- oSample  out  16  signed decoded sample.
- oWarmup  out  1  the current oSample was a warm-up (verbatim) word.
- oOrderErr  out  1  sticky per subframe; the latched order was greater than 4.

Behaviour:
- Reset (iReset=1 at edge, overrides iEnable): oValid=0, oSample=0, oWarmup=0, oOrderErr=0. Stage-1 registers, history s1..s4, warm-up counter and latched order all go to 0. FSM goes to IDLE.
- Reset mid-subframe discards the in-flight word and all history. The next word must carry iStart.
- Pipeline, when iEnable=1:
  - Stage 1 registers iValid, iStart, iOrder, iResidual.
  - Stage 2 computes from the stage-1 registers and the history, then registers the outputs.
  - Latency is exactly 2 enabled cycles from input to oValid. Throughput is one word per enabled cycle.
- iEnable=0 freezes every register, oValid included. Outputs hold their values; no word is lost or duplicated.
- oValid is a one-cycle pulse per accepted word: it drops to 0 on the next enabled cycle that has no stage-1 word.
- FSM states, evaluated on the stage-1 word:
  - IDLE: a word without iStart is dropped (no oValid). A word with iStart latches the order, clears s1..s4, sets oOrderErr=(order>4), then processes the word as below.
  - WARMUP: the word is output verbatim as oSample=iResidual[15:0] with oWarmup=1, and is pushed into history. When warm-up count equals the order, go to DECODE.
  - DECODE: oSample=(residual+pred)[15:0], oWarmup=0, result pushed into history.
  - A start word with order 0 goes directly to DECODE. An order-0 start word itself is decoded with pred=0.
- A start word while in WARMUP or DECODE restarts the subframe immediately: history cleared, new order latched, oOrderErr re-evaluated. The previous subframe is not flushed.
- Orders 5-7 decode as order 0 and hold oOrderErr=1 until the next start word or reset.
- History push: s4<=s3, s3<=s2, s2<=s1, s1<=new oSample (the 16-bit value).
- Prediction, evaluated in RES_W+4 signed bits:
  - o0: 0
  - o1: s1
  - o2: 2s1-s2
  - o3: 3s1-3s2+s3
  - o4: 4s1-6s2+4s3-s4
- Output is the low 16 bits of the sum, i.e. two's-complement wrap with no saturation.
- Back-to-back words: the history used by word n includes word n-1's result. Prediction, add and history update therefore complete within the single stage-2 cycle, with no bubbles.

Test Plan:
- Order-0 decode: start/order0 with residuals 5,-3,100 on consecutive cycles -> oSample 5,-3,100; first oValid 2 cycles after the first iValid; oWarmup=0 throughout.
- Order-2 decode: start/order2, words 10,12,1,-2 -> oSample 10,12,15,16; oWarmup 1,1,0,0.
- Order-4 decode with stall: warm-ups 1,2,3,4 then residual 0, with iEnable low for 3 cycles between words 3 and 4 -> oSample 1,2,3,4,5; outputs held during the stall; no duplicate oValid.
- Mid-block restart: order1 start 100, residual 1, then start/order0 residual 7 -> oSample 100,101,7, with the last output undisturbed by the old history.
- Order error and reset: start/order6, residual 9 -> oSample 9, oOrderErr=1. Then assert iReset mid-stream -> all outputs 0 next cycle, and non-start words are dropped until a new start.
- Wrap: order1 warm-up 32767, residual 1 -> oSample -32768.
